// File: rtl/mem_io_ctrl_if.sv
// FSM-side access bus of mem_io_ctrl: request strobes, address/data and the
// ready/read-data return path.
interface mem_io_ctrl_if;
    // Handshake: master raises mio_en with rw/mar/mdr_in valid and holds mio_en
    // until it sees the one-cycle r pulse; rdata is valid from the r cycle until
    // mio_en drops and a new access is started.
    logic        mio_en;
    logic        rw;
    logic [15:0] mar;
    logic [15:0] mdr_in;
    logic        r;
    logic [15:0] rdata;

    modport master (
        output mio_en, rw, mar, mdr_in,
        input  r, rdata
    );

    modport slave (
        input  mio_en, rw, mar, mdr_in,
        output r, rdata
    );
endinterface

// File: rtl/mem_io_ctrl.sv
// LC-3 memory/IO controller: sequences RAM accesses with a fixed read latency
// and implements the memory-mapped keyboard and display registers.
module mem_io_ctrl #(
    parameter int RAM_LAT = 1
) (
    input  logic             i_Clk,
    input  logic             reset,
    mem_io_ctrl_if.slave     bus,
    output logic             ram_en,
    output logic             ram_we,
    output logic [15:0]      ram_addr,
    output logic [15:0]      ram_wdata,
    input  logic [15:0]      ram_rdata,
    input  logic             kb_valid,
    input  logic [7:0]       kb_data,
    output logic             dsp_valid,
    output logic [7:0]       dsp_data,
    input  logic             dsp_ready,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        READY  = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] IO_BASE   = 16'hFE00;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ram_en_q, ram_en_d;
    logic        ram_we_q, ram_we_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_wdata_q, ram_wdata_d;
    logic        kb_rdy_q, kb_rdy_d;
    logic        kb_ie_q, kb_ie_d;
    logic [7:0]  kbdr_q, kbdr_d;
    logic        dsr_rdy_q, dsr_rdy_d;
    logic        dsp_valid_q, dsp_valid_d;
    logic [7:0]  dsp_data_q, dsp_data_d;

    logic        is_ram;
    logic [15:0] dev_rdata;
    logic        kb_clr;
    logic        ddr_wr;

    // The latched address doubles as the RAM address register.
    assign is_ram = (ram_addr_q < IO_BASE);

    always_comb begin
        dev_rdata = 16'h0000;
        case (ram_addr_q)
            KBSR_ADDR: dev_rdata = {kb_rdy_q, kb_ie_q, 14'd0};
            KBDR_ADDR: dev_rdata = {8'd0, kbdr_q};
            DSR_ADDR:  dev_rdata = {dsr_rdy_q, 15'd0};
            DDR_ADDR:  dev_rdata = {8'd0, dsp_data_q};
            default:   dev_rdata = 16'h0000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        rdata_d     = rdata_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        kb_rdy_d    = kb_rdy_q;
        kb_ie_d     = kb_ie_q;
        kbdr_d      = kbdr_q;
        dsr_rdy_d   = dsr_rdy_q;
        dsp_valid_d = dsp_valid_q;
        dsp_data_d  = dsp_data_q;
        kb_clr      = 1'b0;
        ddr_wr      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.mio_en) begin
                    ram_addr_d  = bus.mar;
                    ram_wdata_d = bus.mdr_in;
                    wr_d        = bus.rw;
                    if (bus.mar < IO_BASE) begin
                        cnt_d    = 4'(RAM_LAT + 1);
                        ram_en_d = 1'b1;
                        ram_we_d = bus.rw;
                    end else begin
                        cnt_d = 4'd0;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // A device access loads 0 and a RAM access counts down to 1;
                // either way the last ACCESS cycle is the one that sees cnt <= 1.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = READY;
                    if (!wr_q) begin
                        rdata_d = is_ram ? ram_rdata : dev_rdata;
                        kb_clr  = (ram_addr_q == KBDR_ADDR);
                    end else begin
                        if (ram_addr_q == KBSR_ADDR) kb_ie_d = ram_wdata_q[14];
                        ddr_wr = (ram_addr_q == DDR_ADDR);
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            READY: state_d = HOLD;
            HOLD: begin
                if (!bus.mio_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Keystrokes are qualified by the pre-clear ready bit, so a key that
        // lands on a completing KBDR read is dropped.
        if (kb_clr) kb_rdy_d = 1'b0;
        if (kb_valid && !kb_rdy_q) begin
            kb_rdy_d = 1'b1;
            kbdr_d   = kb_data;
        end

        if (dsp_valid_q && dsp_ready) begin
            dsp_valid_d = 1'b0;
            dsr_rdy_d   = 1'b1;
        end
        if (ddr_wr && dsr_rdy_q) begin
            dsp_data_d  = ram_wdata_q[7:0];
            dsp_valid_d = 1'b1;
            dsr_rdy_d   = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            rdata_q     <= 16'h0000;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 16'h0000;
            ram_wdata_q <= 16'h0000;
            kb_rdy_q    <= 1'b0;
            kb_ie_q     <= 1'b0;
            kbdr_q      <= 8'h00;
            dsr_rdy_q   <= 1'b1;
            dsp_valid_q <= 1'b0;
            dsp_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            rdata_q     <= rdata_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            kb_rdy_q    <= kb_rdy_d;
            kb_ie_q     <= kb_ie_d;
            kbdr_q      <= kbdr_d;
            dsr_rdy_q   <= dsr_rdy_d;
            dsp_valid_q <= dsp_valid_d;
            dsp_data_q  <= dsp_data_d;
        end
    end

    assign bus.r     = (state_q == READY);
    assign bus.rdata = rdata_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign dsp_valid = dsp_valid_q;
    assign dsp_data  = dsp_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Bench for mem_io_ctrl: two instances (RAM_LAT=1 and RAM_LAT=3) share one
// stimulus stream; a monitor checks every r pulse against an expected queue.
module tb_mem_io_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        mio_en, rw;
    logic [15:0] mar, mdr_in;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        dsp_ready;

    mem_io_ctrl_if bus_a ();
    mem_io_ctrl_if bus_b ();
    assign bus_a.mio_en = mio_en;
    assign bus_a.rw     = rw;
    assign bus_a.mar    = mar;
    assign bus_a.mdr_in = mdr_in;
    assign bus_b.mio_en = mio_en;
    assign bus_b.rw     = rw;
    assign bus_b.mar    = mar;
    assign bus_b.mdr_in = mdr_in;

    logic        ram_en_a, ram_we_a, ram_en_b, ram_we_b;
    logic [15:0] ram_addr_a, ram_wdata_a, ram_rdata_a;
    logic [15:0] ram_addr_b, ram_wdata_b, ram_rdata_b;
    logic        dsp_valid_a, dsp_valid_b;
    logic [7:0]  dsp_data_a, dsp_data_b;
    logic [1:0]  state_a, state_b;

    mem_io_ctrl #(.RAM_LAT(1)) u_dut_a (
        .i_Clk(clk), .reset(reset), .bus(bus_a),
        .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a),
        .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata_a),
        .kb_valid(kb_valid), .kb_data(kb_data),
        .dsp_valid(dsp_valid_a), .dsp_data(dsp_data_a), .dsp_ready(dsp_ready),
        .dbg_state(state_a)
    );

    mem_io_ctrl #(.RAM_LAT(3)) u_dut_b (
        .i_Clk(clk), .reset(reset), .bus(bus_b),
        .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b),
        .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b),
        .kb_valid(kb_valid), .kb_data(kb_data),
        .dsp_valid(dsp_valid_b), .dsp_data(dsp_data_b), .dsp_ready(dsp_ready),
        .dbg_state(state_b)
    );

    // Synchronous RAM models with 1- and 3-cycle read latency
    logic        pre_en;
    logic [15:0] pre_addr, pre_data;
    logic [15:0] mem_a [0:65535];
    logic [15:0] mem_b [0:65535];
    logic [15:0] rd_a, pipe_b0, pipe_b1, pipe_b2;

    always @(posedge clk) begin
        if (pre_en) begin
            mem_a[pre_addr] <= pre_data;
            mem_b[pre_addr] <= pre_data;
        end else begin
            if (ram_en_a && ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;
            if (ram_en_b && ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
        end
        if (ram_en_a && !ram_we_a) rd_a <= mem_a[ram_addr_a];
        if (ram_en_b && !ram_we_b) pipe_b0 <= mem_b[ram_addr_b];
        pipe_b1 <= pipe_b0;
        pipe_b2 <= pipe_b1;
    end
    assign ram_rdata_a = rd_a;
    assign ram_rdata_b = pipe_b2;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t_start = 0;
    int r_cnt_a, r_cnt_b, en_cnt_a, en_cnt_b, we_cnt_a, en_lat_a, en_lat_b;

    // {check_data, latency[7:0], rdata[15:0]}
    logic [24:0] exp_a_q[$];
    logic [24:0] exp_b_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    initial begin
        logic [24:0] e;
        int lat;
        r_cnt_a = 0; r_cnt_b = 0; en_cnt_a = 0; en_cnt_b = 0;
        we_cnt_a = 0; en_lat_a = 0; en_lat_b = 0;
        forever begin
            @(negedge clk);
            lat = cyc - t_start;
            if (ram_en_a) begin
                en_cnt_a++;
                en_lat_a = lat;
                if (ram_we_a) we_cnt_a++;
            end
            if (ram_en_b) begin
                en_cnt_b++;
                en_lat_b = lat;
            end
            if (bus_a.r === 1'b1) begin
                r_cnt_a++;
                n_vec++;
                if (exp_a_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp_a: got unexpected r pulse at cycle %0d, required no pulse", cyc);
                end else begin
                    e = exp_a_q.pop_front();
                    if (lat != int'(e[23:16]) || (e[24] && bus_a.rdata !== e[15:0])) begin
                        n_err++;
                        $display("FAIL rsp_a: got lat %0d rdata %h, required lat %0d rdata %h",
                                 lat, bus_a.rdata, e[23:16], e[15:0]);
                    end
                end
            end
            if (bus_b.r === 1'b1) begin
                r_cnt_b++;
                n_vec++;
                if (exp_b_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp_b: got unexpected r pulse at cycle %0d, required no pulse", cyc);
                end else begin
                    e = exp_b_q.pop_front();
                    if (lat != int'(e[23:16]) || (e[24] && bus_b.rdata !== e[15:0])) begin
                        n_err++;
                        $display("FAIL rsp_b: got lat %0d rdata %h, required lat %0d rdata %h",
                                 lat, bus_b.rdata, e[23:16], e[15:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic acc(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] exp, input bit early);
        bit is_ram;
        int ra, rb, ea, eb, wa, k;
        is_ram = (a < 16'hFE00);
        @(posedge clk); #1;
        mio_en = 1'b1; rw = w; mar = a; mdr_in = d;
        t_start = cyc;
        ra = r_cnt_a; rb = r_cnt_b; ea = en_cnt_a; eb = en_cnt_b; wa = we_cnt_a;
        exp_a_q.push_back({~w, is_ram ? 8'd3 : 8'd2, exp});
        exp_b_q.push_back({~w, is_ram ? 8'd5 : 8'd2, exp});
        @(posedge clk); #1;
        rw = ~w; mar = ~a; mdr_in = ~d;
        if (early) begin
            @(posedge clk); #1;
            mio_en = 1'b0;
        end
        k = 0;
        while ((r_cnt_a == ra || r_cnt_b == rb) && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        n_vec++;
        if (k >= 40) begin
            n_err++;
            $display("FAIL timeout: got no r within 40 cycles for addr %h, required r", a);
            exp_a_q.delete();
            exp_b_q.delete();
        end
        if (!w && !early) begin
            @(posedge clk); #1;
            chk("hold_rdata_a", bus_a.rdata, exp);
            chk("hold_rdata_b", bus_b.rdata, exp);
        end
        mio_en = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("idle_a", 16'(state_a), 16'd0);
        chk("idle_b", 16'(state_b), 16'd0);
        chk("ram_en_count_a", 16'(en_cnt_a - ea), is_ram ? 16'd1 : 16'd0);
        chk("ram_en_count_b", 16'(en_cnt_b - eb), is_ram ? 16'd1 : 16'd0);
        chk("ram_we_count_a", 16'(we_cnt_a - wa), (is_ram && w) ? 16'd1 : 16'd0);
        if (is_ram) begin
            chk("ram_en_lat_a", 16'(en_lat_a), 16'd1);
            chk("ram_en_lat_b", 16'(en_lat_b), 16'd1);
        end
    endtask

    task automatic key(input logic [7:0] c);
        @(posedge clk); #1;
        kb_valid = 1'b1; kb_data = c;
        @(posedge clk); #1;
        kb_valid = 1'b0;
    endtask

    initial begin
        int ra, rb;
        reset = 1'b1; mio_en = 1'b0; rw = 1'b0; mar = 16'h0; mdr_in = 16'h0;
        kb_valid = 1'b0; kb_data = 8'h0; dsp_ready = 1'b0;
        pre_en = 1'b0; pre_addr = 16'h0; pre_data = 16'h0;
        #2;
        chk("rst_r", 16'(bus_a.r), 16'd0);
        chk("rst_rdata", bus_a.rdata, 16'h0000);
        chk("rst_ram_en_we", {14'd0, ram_en_a, ram_we_a}, 16'd0);
        chk("rst_ram_addr", ram_addr_a, 16'h0000);
        chk("rst_ram_wdata", ram_wdata_a, 16'h0000);
        chk("rst_dsp", {7'd0, dsp_valid_a, dsp_data_a}, 16'h0000);
        chk("rst_state", 16'(state_a), 16'd0);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = 16'h3000; pre_data = 16'h1234;
        @(posedge clk); #1;
        pre_en = 1'b0; reset = 1'b0;

        // RAM
        acc(1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b0);
        acc(1'b1, 16'hFDFF, 16'h00FF, 16'h0000, 1'b0);
        acc(1'b0, 16'hFDFF, 16'h0000, 16'h00FF, 1'b0);
        acc(1'b1, 16'h0000, 16'h0ABC, 16'h0000, 1'b0);
        acc(1'b0, 16'h0000, 16'h0000, 16'h0ABC, 1'b0);

        // Keyboard
        key(8'h41);
        acc(1'b0, 16'hFE00, 16'h0000, 16'h8000, 1'b0);
        key(8'h42);
        acc(1'b0, 16'hFE02, 16'h0000, 16'h0041, 1'b0);
        acc(1'b0, 16'hFE00, 16'h0000, 16'h0000, 1'b0);
        acc(1'b1, 16'hFE00, 16'hFFFF, 16'h0000, 1'b0);
        acc(1'b0, 16'hFE00, 16'h0000, 16'h4000, 1'b0);

        // Display
        acc(1'b1, 16'hFE06, 16'h0058, 16'h0000, 1'b0);
        chk("dsp_valid_set", 16'(dsp_valid_a), 16'd1);
        chk("dsp_data_58", 16'(dsp_data_a), 16'h0058);
        acc(1'b0, 16'hFE04, 16'h0000, 16'h0000, 1'b0);
        acc(1'b1, 16'hFE06, 16'h0059, 16'h0000, 1'b0);
        chk("dsp_data_kept", 16'(dsp_data_b), 16'h0058);
        acc(1'b0, 16'hFE06, 16'h0000, 16'h0058, 1'b0);
        @(posedge clk); #1;
        dsp_ready = 1'b1;
        @(posedge clk); #1;
        dsp_ready = 1'b0;
        chk("dsp_valid_clr", 16'(dsp_valid_a), 16'd0);
        acc(1'b0, 16'hFE04, 16'h0000, 16'h8000, 1'b0);

        // Unmapped and early mio_en release
        acc(1'b0, 16'hFE10, 16'h0000, 16'h0000, 1'b0);
        acc(1'b1, 16'hFFFF, 16'h00AA, 16'h0000, 1'b0);
        acc(1'b1, 16'hFE01, 16'h00BB, 16'h0000, 1'b0);
        acc(1'b0, 16'hFE00, 16'h0000, 16'h4000, 1'b0);
        acc(1'b0, 16'hFE04, 16'h0000, 16'h8000, 1'b0);
        acc(1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b1);

        // Reset in the middle of a read with a display character pending
        acc(1'b1, 16'hFE06, 16'h005A, 16'h0000, 1'b0);
        chk("dsp_pending", {7'd0, dsp_valid_a, dsp_data_a}, 16'h015A);
        @(posedge clk); #1;
        mio_en = 1'b1; rw = 1'b0; mar = 16'h3000; t_start = cyc;
        ra = r_cnt_a; rb = r_cnt_b;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midrst_rdata_a", bus_a.rdata, 16'h0000);
        chk("midrst_rdata_b", bus_b.rdata, 16'h0000);
        chk("midrst_ram_en_b", 16'(ram_en_b), 16'd0);
        chk("midrst_state_b", 16'(state_b), 16'd0);
        chk("midrst_dsp", {7'd0, dsp_valid_a, dsp_data_a}, 16'h0000);
        mio_en = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_r_a", 16'(r_cnt_a - ra), 16'd0);
        chk("midrst_no_r_b", 16'(r_cnt_b - rb), 16'd0);
        acc(1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b0);
        acc(1'b0, 16'hFE04, 16'h0000, 16'h8000, 1'b0);
        acc(1'b0, 16'hFE00, 16'h0000, 16'h0000, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("exp_a_drained", 16'(exp_a_q.size()), 16'd0);
        chk("exp_b_drained", 16'(exp_b_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
